// File: rtl/md_unit_param_if.sv
// md_unit_param_if: operand/control/result bundle between EX decode and the
// multiply/divide unit.
//   master (EX decode): drives a, b, op, start, mthi, mtlo, flush
//   slave  (md unit)  : drives busy, done, div_zero, hi, lo
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             start;
    logic             mthi;
    logic             mtlo;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, op, start, mthi, mtlo, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  a, b, op, start, mthi, mtlo, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply / multiply-accumulate / divide unit
// with HI/LO registers for the EX stage.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of md_unit_param_if
//                a, b, op, start, mthi, mtlo, flush in;
//                busy, done, div_zero, hi, lo out
// The result is computed combinationally from operands latched at accept;
// the counter only models the fixed busy window before HI/LO are written.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    md_unit_param_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    CNT_DIV  = CW'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, hi_base, lo_base;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [2:0]       op_q;
    logic             done_q, dz_q;
    logic             accept, finish, op_is_div, new_is_div;

    assign new_is_div = (bus.op[2:1] == 2'b01);
    assign op_is_div  = (op_q[2:1] == 2'b01);
    // flush wins over start in IDLE and cancels the op in RUN
    assign accept = (state_q == IDLE) && bus.start && !bus.flush;
    assign finish = (state_q == RUN) && !bus.flush && (cnt_q == CNT_ONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (bus.flush || (cnt_q == CNT_ONE)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == RUN);
        bus.done     = done_q;
        bus.div_zero = dz_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

    // ---------------- arithmetic ----------------
    logic [2*WIDTH-1:0] ax, bx, prod, base, mres;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b, q_mag, r_mag, quo, rem;

    always_comb begin
        // sign- or zero-extend to 2*WIDTH; the truncated product is then
        // correct modulo 2^(2*WIDTH) for both signed and unsigned operands
        ax   = op_q[0] ? {ZERO, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        bx   = op_q[0] ? {ZERO, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod = ax * bx;
        base = {hi_base, lo_base};
        case (op_q[2:1])
            2'b10:   mres = base + prod;
            2'b11:   mres = base - prod;
            default: mres = prod;
        endcase
    end

    always_comb begin
        // signed divide via magnitudes; most-negative / -1 wraps back to a
        sgn_a = !op_q[0] && a_q[WIDTH-1];
        sgn_b = !op_q[0] && b_q[WIDTH-1];
        mag_a = sgn_a ? (ZERO - a_q) : a_q;
        mag_b = sgn_b ? (ZERO - b_q) : b_q;
        q_mag = (b_q == ZERO) ? ZERO : (mag_a / mag_b);
        r_mag = (b_q == ZERO) ? ZERO : (mag_a % mag_b);
        quo   = (sgn_a ^ sgn_b) ? (ZERO - q_mag) : q_mag;
        rem   = sgn_a ? (ZERO - r_mag) : r_mag;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_base <= '0;
            lo_base <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                op_q    <= bus.op;
                hi_base <= hi_q;
                lo_base <= lo_q;
                cnt_q   <= new_is_div ? CNT_DIV : CNT_MULT;
                dz_q    <= new_is_div && (bus.b == ZERO);
            end else if ((state_q == IDLE) && !bus.start) begin
                if (bus.mthi) hi_q <= bus.a;
                if (bus.mtlo) lo_q <= bus.a;
            end
            if (state_q == RUN) cnt_q <= cnt_q - CNT_ONE;
            if (finish) begin
                if (!op_is_div) begin
                    {hi_q, lo_q} <= mres;
                end else if (b_q != ZERO) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end
            end
        end
    end
endmodule

// File: tb/tb_md_unit_param.sv
module tb_md_unit_param;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_param_if #(.WIDTH(W)) bus();

    md_unit_param #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   ntest = 0;
    int   nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op, push its expected result, then follow it to done.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int n,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        exp_t e;
        int   cyc;
        bit   got;
        @(posedge clk); #1;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        e.hi = ehi; e.lo = elo; e.dz = edz;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= n + 4) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else begin
                check({tag, ":busy"}, 64'(bus.busy), 64'(1));
                cyc++;
            end
        end
        check({tag, ":latency"}, got ? 64'(cyc) : 64'(0), 64'(n + 1));
        e = sb.pop_front();
        if (got) begin
            check({tag, ":busy_at_done"}, 64'(bus.busy), 64'(0));
            check({tag, ":hi"}, 64'(bus.hi), 64'(e.hi));
            check({tag, ":lo"}, 64'(bus.lo), 64'(e.lo));
            check({tag, ":div_zero"}, 64'(bus.div_zero), 64'(e.dz));
            @(negedge clk);
            check({tag, ":done_pulse"}, 64'(bus.done), 64'(0));
        end
    endtask

    initial begin
        bit seen_done;
        bus.a = '0; bus.b = '0; bus.op = 3'b000;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.flush = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst:hi", 64'(bus.hi), 64'(0));
        check("rst:lo", 64'(bus.lo), 64'(0));
        check("rst:busy", 64'(bus.busy), 64'(0));
        check("rst:done", 64'(bus.done), 64'(0));
        check("rst:dz", 64'(bus.div_zero), 64'(0));

        // signed mult -1 * 2
        run_op("mult", 3'b000, 32'hFFFF_FFFF, 32'd2, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        // divides
        run_op("divu", 3'b011, 32'd7, 32'd2, DC, 32'd1, 32'd3, 1'b0);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000, 1'b0);

        // moves, then divide by zero leaves HI/LO alone
        @(posedge clk); #1 bus.mthi = 1'b1; bus.a = 32'h11;
        @(posedge clk); #1 bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.a = 32'h22;
        @(posedge clk); #1 bus.mtlo = 1'b0;
        @(negedge clk);
        check("mthi", 64'(bus.hi), 64'h11);
        check("mtlo", 64'(bus.lo), 64'h22);
        run_op("div0", 3'b010, 32'd5, 32'd0, DC, 32'h11, 32'h22, 1'b1);
        // next start clears div_zero
        run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        // accumulate modes
        @(posedge clk); #1 bus.mthi = 1'b1; bus.a = 32'h0;
        @(posedge clk); #1 bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.a = 32'hFFFF_FFFF;
        @(posedge clk); #1 bus.mtlo = 1'b0;
        run_op("maddu", 3'b101, 32'd1, 32'd1, MC, 32'd1, 32'd0, 1'b0);
        run_op("msubu", 3'b111, 32'd1, 32'd1, MC, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("madd", 3'b100, 32'hFFFF_FFFF, 32'd1, MC, 32'd0, 32'hFFFF_FFFE, 1'b0);
        run_op("msub", 3'b110, 32'hFFFF_FFFE, 32'd3, MC, 32'd1, 32'd4, 1'b0);

        // start with flush in IDLE is dropped
        @(posedge clk); #1 bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000;
        @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("idle_flush:busy", 64'(bus.busy), 64'(0));

        // flush in RUN; start+mthi while busy ignored
        @(posedge clk); #1 bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd3;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 bus.start = 1'b1; bus.mthi = 1'b1; bus.a = 32'h55;
        @(posedge clk); #1 bus.start = 1'b0; bus.mthi = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        check("flush:busy_t3", 64'(bus.busy), 64'(1));
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush:busy_t4", 64'(bus.busy), 64'(0));
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_done = seen_done | bus.done | bus.busy;
        end
        check("flush:no_done", 64'(seen_done), 64'(0));
        check("flush:hi", 64'(bus.hi), 64'(1));
        check("flush:lo", 64'(bus.lo), 64'(4));

        // reset in cycle t+2 of a divide
        @(posedge clk); #1 bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd9; bus.b = 32'd0;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        check("rst_mid:dz_before", 64'(bus.div_zero), 64'(1));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid:hi", 64'(bus.hi), 64'(0));
        check("rst_mid:lo", 64'(bus.lo), 64'(0));
        check("rst_mid:busy", 64'(bus.busy), 64'(0));
        check("rst_mid:done", 64'(bus.done), 64'(0));
        check("rst_mid:dz", 64'(bus.div_zero), 64'(0));
        run_op("post_rst_divu", 3'b011, 32'd100, 32'd7, DC, 32'd2, 32'd14, 1'b0);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
